// File: rtl/dfr_pkg.sv
// Shared types for the delayed-feedback reservoir phase sequencer.
// Holds the phase and FSM state encodings, the CTRL start bit index and a state-to-phase helper.
package dfr_pkg;

    localparam int START_BIT = 0;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_INIT  = 2'd1,
        PH_TRAIN = 2'd2,
        PH_TEST  = 2'd3
    } phase_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_TRAIN,
        S_TEST,
        S_READOUT,
        S_DONE
    } seq_state_t;

    // READOUT belongs to the TEST phase as far as software is concerned.
    function automatic phase_t phase_of(seq_state_t s);
        case (s)
            S_INIT:            return PH_INIT;
            S_TRAIN:           return PH_TRAIN;
            S_TEST, S_READOUT: return PH_TEST;
            default:           return PH_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/dfr_step_counter.sv
// Step counter with clear, enable and a terminal flag (count == limit-1); optional wrap to 0.
// last is combinational from the count register; no backpressure, it counts whenever en is high.
module dfr_step_counter #(
    parameter int W    = 32,
    parameter bit WRAP = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         last
);

    logic [W-1:0] count;

    assign last = (count == (limit - W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (WRAP && last) ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/dfr_phase_sequencer.sv
// Sequences a reservoir run through INIT/TRAIN/TEST, one step per valid/ready handshake, with TEST readouts.
// Launch takes two cycles after the start edge; step_valid holds until step_ready, readout_req until readout_ack.
module dfr_phase_sequencer
    import dfr_pkg::*;
#(
    parameter int INPUT_ADDR_WIDTH  = 17,
    parameter int OUTPUT_ADDR_WIDTH = 17,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                         S_AXI_ACLK,
    input  logic                         S_AXI_ARESETN,
    input  logic                         start,
    input  logic [CNT_WIDTH-1:0]         num_init_steps,
    input  logic [CNT_WIDTH-1:0]         num_train_steps,
    input  logic [CNT_WIDTH-1:0]         num_test_steps,
    input  logic [CNT_WIDTH-1:0]         num_steps_per_sample,
    output logic                         step_valid,
    input  logic                         step_ready,
    output logic [INPUT_ADDR_WIDTH-1:0]  input_addr,
    output logic [1:0]                   phase,
    output logic                         sample_end,
    output logic                         readout_req,
    input  logic                         readout_ack,
    output logic                         output_wr_en,
    output logic [OUTPUT_ADDR_WIDTH-1:0] output_addr,
    output logic                         busy,
    output logic                         cfg_error
);

    seq_state_t           state, state_nxt;
    logic [START_BIT:0]   ctrl_q;
    logic                 start_prev, start_edge, cfg_bad;
    logic                 launch, refuse, ph_clr, ph_end;
    logic                 hs, ph_last, smp_last;
    logic [CNT_WIDTH-1:0] ph_limit;

    assign start_edge   = ctrl_q[START_BIT] & ~start_prev;
    assign cfg_bad      = (num_steps_per_sample == '0) ||
                          ((num_init_steps | num_train_steps | num_test_steps) == '0);
    // ph_end parks the phase after its final handshake so the next phase is chosen one cycle later.
    assign step_valid   = (state inside {S_INIT, S_TRAIN, S_TEST}) && !ph_end;
    assign hs           = step_valid && step_ready;
    assign sample_end   = hs && smp_last;
    assign readout_req  = (state == S_READOUT);
    assign output_wr_en = readout_req && readout_ack;
    assign busy         = (state != S_IDLE);
    assign phase        = phase_of(state);

    always_comb begin
        case (state)
            S_INIT:  ph_limit = num_init_steps;
            S_TRAIN: ph_limit = num_train_steps;
            default: ph_limit = num_test_steps;
        endcase
    end

    dfr_step_counter #(.W(CNT_WIDTH), .WRAP(1'b0)) u_phase_cnt (
        .clk   (S_AXI_ACLK),
        .rst_n (S_AXI_ARESETN),
        .clr   (ph_clr),
        .en    (hs),
        .limit (ph_limit),
        .last  (ph_last)
    );

    // The in-sample position is cleared only at launch so samples straddle phase boundaries.
    dfr_step_counter #(.W(CNT_WIDTH), .WRAP(1'b1)) u_sample_cnt (
        .clk   (S_AXI_ACLK),
        .rst_n (S_AXI_ARESETN),
        .clr   (launch),
        .en    (hs),
        .limit (num_steps_per_sample),
        .last  (smp_last)
    );

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        refuse    = 1'b0;
        ph_clr    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_edge) begin
                    if (cfg_bad) begin
                        refuse = 1'b1;
                    end else begin
                        launch    = 1'b1;
                        ph_clr    = 1'b1;
                        state_nxt = (num_init_steps  != '0) ? S_INIT  :
                                    (num_train_steps != '0) ? S_TRAIN : S_TEST;
                    end
                end
            end
            S_INIT, S_TRAIN, S_TEST: begin
                if (ph_end) begin
                    ph_clr = 1'b1;
                    if (state == S_INIT && num_train_steps != '0) begin
                        state_nxt = S_TRAIN;
                    end else if (state != S_TEST && num_test_steps != '0) begin
                        state_nxt = S_TEST;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end else if (state == S_TEST && sample_end) begin
                    state_nxt = S_READOUT;
                end
            end
            S_READOUT: begin
                if (readout_ack) begin
                    state_nxt = S_TEST;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state       <= S_IDLE;
            ctrl_q      <= '0;
            start_prev  <= 1'b0;
            ph_end      <= 1'b0;
            input_addr  <= '0;
            output_addr <= '0;
            cfg_error   <= 1'b0;
        end else begin
            state              <= state_nxt;
            ctrl_q[START_BIT]  <= start;
            start_prev         <= ctrl_q[START_BIT];
            if (ph_clr) begin
                ph_end <= 1'b0;
            end else if (hs && ph_last) begin
                ph_end <= 1'b1;
            end
            if (launch) begin
                input_addr <= '0;
            end else if (hs) begin
                input_addr <= input_addr + INPUT_ADDR_WIDTH'(1);
            end
            if (launch) begin
                output_addr <= '0;
            end else if (output_wr_en) begin
                output_addr <= output_addr + OUTPUT_ADDR_WIDTH'(1);
            end
            if (refuse) begin
                cfg_error <= 1'b1;
            end else if (launch) begin
                cfg_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dfr_phase_sequencer.sv
// Randomized bench for dfr_phase_sequencer: a step-index model predicts address, phase, sample ends and writes.
module tb_dfr_phase_sequencer;

    localparam int IAW = 17;
    localparam int OAW = 17;
    localparam int CW  = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [CW-1:0]  num_init_steps = '0, num_train_steps = '0, num_test_steps = '0, num_steps_per_sample = '0;
    logic           step_valid, step_ready = 1'b1;
    logic [IAW-1:0] input_addr;
    logic [1:0]     phase;
    logic           sample_end, readout_req, readout_ack = 1'b0, output_wr_en;
    logic [OAW-1:0] output_addr;
    logic           busy, cfg_error;

    dfr_phase_sequencer #(.INPUT_ADDR_WIDTH(IAW), .OUTPUT_ADDR_WIDTH(OAW), .CNT_WIDTH(CW)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start),
        .num_init_steps(num_init_steps), .num_train_steps(num_train_steps),
        .num_test_steps(num_test_steps), .num_steps_per_sample(num_steps_per_sample),
        .step_valid(step_valid), .step_ready(step_ready), .input_addr(input_addr),
        .phase(phase), .sample_end(sample_end), .readout_req(readout_req),
        .readout_ack(readout_ack), .output_wr_en(output_wr_en), .output_addr(output_addr),
        .busy(busy), .cfg_error(cfg_error)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int ci = 0, ct = 0, cx = 0, cp = 1, n_exp = 0;
    int hs_idx = 0, wr_idx = 0, sv_cnt = 0, last_addr = -1;
    bit pend = 0, saw_train = 0, prev_sv = 0, prev_sr = 0;
    int se_q[$];
    bit rdy_rand = 0, spur = 0;
    int ack_dly = 3, wait_cnt = 0;

    task automatic check(input string name, input int act, input int want);
        tests++;
        if (act != want) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic int exp_phase(input int j);
        return (j < ci) ? 1 : (j < ci + ct) ? 2 : 3;
    endfunction

    function automatic bit exp_se(input int j);
        return (cp != 0) && (((j + 1) % cp) == 0);
    endfunction

    // Responders: random ready and a readout_ack ack_dly cycles into each request.
    always @(posedge clk) begin
        #1;
        step_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!rst_n) begin
            readout_ack = 1'b0;
            wait_cnt    = 0;
        end else if (readout_req) begin
            if (wait_cnt >= ack_dly) begin
                readout_ack = 1'b1;
            end else begin
                readout_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            readout_ack = spur ? ($urandom_range(0, 3) == 0) : 1'b0;
            wait_cnt    = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_sv = 0;
            prev_sr = 0;
        end else begin
            if (step_valid) sv_cnt++;
            if (phase == 2'd2) saw_train = 1;
            if (prev_sv && !prev_sr) check("sv_hold", int'(step_valid), 1);
            if (step_valid) begin
                check("sv_during_readout", int'(pend), 0);
                check("input_addr", int'(input_addr), hs_idx % (1 << IAW));
                check("phase_step", int'(phase), exp_phase(hs_idx));
            end
            if (step_valid && step_ready) begin
                check("sample_end", int'(sample_end), int'(exp_se(hs_idx)));
                if (sample_end) se_q.push_back(hs_idx);
                if (exp_se(hs_idx) && hs_idx >= ci + ct) pend = 1;
                last_addr = int'(input_addr);
                hs_idx++;
                check("step_budget", int'(hs_idx <= n_exp), 1);
            end else begin
                check("sample_end_nohs", int'(sample_end), 0);
            end
            if (readout_req) begin
                check("req_expected", int'(pend), 1);
                check("req_phase", int'(phase), 3);
            end
            if (output_wr_en) begin
                check("wr_expected", int'(pend && readout_req), 1);
                check("output_addr", int'(output_addr), wr_idx);
                wr_idx++;
                pend = 0;
            end
            if (!busy) check("idle_quiet", int'({phase, step_valid, readout_req}), 0);
            prev_sv = step_valid;
            prev_sr = step_ready;
        end
    end

    task automatic arm(input int i, input int t, input int x, input int p);
        ci = i; ct = t; cx = x; cp = p; n_exp = i + t + x;
        num_init_steps = CW'(i); num_train_steps = CW'(t);
        num_test_steps = CW'(x); num_steps_per_sample = CW'(p);
        hs_idx = 0; wr_idx = 0; pend = 0; saw_train = 0; last_addr = -1; sv_cnt = 0;
        se_q.delete();
    endtask

    task automatic launch();
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
    endtask

    task automatic wait_busy();
        for (int k = 0; k < 8 && !busy; k++) @(negedge clk);
        check("busy_rise", int'(busy), 1);
    endtask

    task automatic wait_done(input bit toggle);
        for (int k = 0; k < 5000 && busy; k++) begin
            @(posedge clk); #1;
            if (toggle) start = (k < 200) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        @(negedge clk);
        check("done_timeout", int'(busy), 0);
    endtask

    task automatic end_checks();
        check("total_steps", hs_idx, n_exp);
        check("total_writes", wr_idx, n_exp / cp - (ci + ct) / cp);
        check("total_sample_ends", se_q.size(), n_exp / cp);
        check("readout_drained", int'(pend), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_outputs", int'({step_valid, input_addr, phase, sample_end, readout_req,
                                     output_wr_en, output_addr, busy, cfg_error} != 0), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Skipped TRAIN, full-throughput ready.
        arm(100, 0, 400, 100); rdy_rand = 0; spur = 0; ack_dly = 3;
        launch(); wait_busy(); wait_done(0); end_checks();
        check("t1_steps", hs_idx, 500);
        check("t1_last_addr", last_addr, 499);
        check("t1_sample_ends", se_q.size(), 5);
        check("t1_writes", wr_idx, 4);
        check("t1_no_train", int'(saw_train), 0);

        // Backpressure, spurious acks, start toggling while busy, then start held high.
        arm(100, 0, 400, 100); rdy_rand = 1; spur = 1;
        launch(); wait_busy(); wait_done(1); end_checks();
        check("t2_writes", wr_idx, 4);
        check("t2_last_addr", last_addr, 499);
        sv_cnt = 0;
        repeat (20) @(negedge clk);
        check("hold_no_relaunch", int'(busy), 0);
        check("hold_no_step", sv_cnt, 0);

        // Refused launch, then a good one.
        arm(10, 0, 20, 0); rdy_rand = 0; spur = 0;
        launch();
        repeat (6) @(negedge clk);
        check("cfg_error_set", int'(cfg_error), 1);
        check("cfg_busy_low", int'(busy), 0);
        check("cfg_no_step", sv_cnt, 0);
        arm(10, 0, 20, 10);
        launch(); wait_busy();
        check("cfg_error_cleared", int'(cfg_error), 0);
        wait_done(0); end_checks();
        check("t3_writes", wr_idx, 2);

        // Phase ends mid-sample.
        arm(15, 0, 20, 10); rdy_rand = 1; ack_dly = 0;
        launch(); wait_busy(); wait_done(0); end_checks();
        check("t4_se_count", se_q.size(), 3);
        if (se_q.size() == 3) begin
            check("t4_se0", se_q[0], 9);
            check("t4_se1", se_q[1], 19);
            check("t4_se2", se_q[2], 29);
        end
        check("t4_writes", wr_idx, 2);

        // Reset during the second READOUT.
        arm(100, 0, 400, 100); rdy_rand = 0; ack_dly = 3;
        launch(); wait_busy();
        for (int k = 0; k < 3000 && !(readout_req && wr_idx >= 1); k++) @(negedge clk);
        check("t5_reached_readout", int'(readout_req), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_reset", int'({step_valid, input_addr, phase, sample_end, readout_req,
                                      output_wr_en, output_addr, busy, cfg_error} != 0), 0);
        start = 1'b0;
        repeat (2) @(posedge clk);
        arm(5, 5, 20, 5);
        #1 rst_n = 1'b1;
        launch(); wait_busy(); wait_done(0); end_checks();
        check("t5_writes", wr_idx, 4);
        check("t5_saw_train", int'(saw_train), 1);

        // Random configurations.
        for (int r = 0; r < 4; r++) begin
            int i, t, x, p;
            i = $urandom_range(0, 40); t = $urandom_range(0, 40); x = $urandom_range(0, 60);
            if (i + t + x == 0) x = 7;
            p = $urandom_range(1, 12);
            arm(i, t, x, p); rdy_rand = 1; spur = 1; ack_dly = $urandom_range(0, 4);
            launch(); wait_busy(); wait_done(0); end_checks();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
